score_accum: RTL and testbench

SCORE_ACCUM -- requirements
Module: score_accum

---
 rtl/piano_score_pkg.sv | 25 ++
 rtl/score_accum_key_edge.sv | 30 +++
 rtl/score_accum.sv | 126 ++++++++++++
 tb/tb_score_accum.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_score_pkg.sv
// Shared types for the piano scoring block: FSM states, the 41-bit score type
// and a saturating adder so that the score can never wrap.
package piano_score_pkg;

    localparam int unsigned KEYS    = 7;
    localparam int unsigned SCORE_W = 41;

    typedef logic [SCORE_W-1:0] score_t;

    localparam score_t SCORE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic score_t sat_add(input score_t a, input score_t b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_accum_key_edge.sv
// Two-flop synchronizer for the raw piano switches followed by a registered
// rising-edge detector: key_rise pulses for one cycle, 3 cycles after key_in rises.
module key_edge
    import piano_score_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [KEYS-1:0] key_in,
    output logic [KEYS-1:0] key_rise
);

    logic [KEYS-1:0] sync1;
    logic [KEYS-1:0] sync2;
    logic [KEYS-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            key_rise <= '0;
        end else begin
            sync1    <= key_in;
            sync2    <= sync1;
            prev     <= sync2;
            key_rise <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/score_accum.sv
// Lateness score accumulator for the piano game; wrong-key penalties are
// compiled in only when SCORE_WRONG_KEY_PENALTY_EN is defined.
module score_accum
    import piano_score_pkg::*;
#(
    parameter int unsigned MAX_WAIT      = 100_000_000,
    parameter int unsigned WRONG_PENALTY = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            song_start,
    input  logic            song_end,
    input  logic            note_valid,
    input  logic [KEYS-1:0] expected_note,
    input  logic [KEYS-1:0] key_in,
    output score_t          score,
    output logic            score_valid,
    output logic            note_hit,
    output logic            note_miss,
    output logic            busy,
    output state_t          dbg_state
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    // All control inputs are single-cycle pulses with no backpressure: an event
    // counts in the cycle it is high and only in the states that accept it.

    state_t          state_q, state_d;
    score_t          score_q, score_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEYS-1:0] exp_note_q, exp_note_d;
    logic            hit_d, miss_d;
    logic [KEYS-1:0] key_rise;
    logic            correct_rise;
    logic            timeout;

    key_edge u_key_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_rise (key_rise)
    );

    assign correct_rise = |(key_rise & exp_note_q);
    assign timeout      = (cnt_q == CNT_W'(MAX_WAIT - 1));

`ifdef SCORE_WRONG_KEY_PENALTY_EN
    logic wrong_rise;
    assign wrong_rise = |(key_rise & ~exp_note_q);
`else
    logic unused_penalty;
    assign unused_penalty = ^WRONG_PENALTY;
`endif

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        cnt_d      = cnt_q;
        exp_note_d = exp_note_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        if (song_start) begin
            state_d = ARMED;
            score_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (song_end) begin
                        state_d = DONE;
                    end else if (note_valid) begin
                        exp_note_d = expected_note;
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    // A pending note at song end is charged as fully late.
                    if (song_end) begin
                        score_d = sat_add(score_q, score_t'(MAX_WAIT));
                        state_d = DONE;
                    end else if (correct_rise) begin
                        score_d = sat_add(score_q, score_t'(cnt_q));
                        hit_d   = 1'b1;
                        state_d = ARMED;
                    end else if (timeout) begin
                        score_d = sat_add(score_q, score_t'(MAX_WAIT));
                        miss_d  = 1'b1;
                        state_d = ARMED;
`ifdef SCORE_WRONG_KEY_PENALTY_EN
                    end else if (wrong_rise) begin
                        score_d = sat_add(score_q, score_t'(WRONG_PENALTY));
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            score_q    <= '0;
            cnt_q      <= '0;
            exp_note_q <= '0;
            note_hit   <= 1'b0;
            note_miss  <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            cnt_q      <= cnt_d;
            exp_note_q <= exp_note_d;
            note_hit   <= hit_d;
            note_miss  <= miss_d;
        end
    end

    assign score       = score_q;
    assign score_valid = (state_q == DONE);
    assign busy        = (state_q == WAIT);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_score_accum.sv
// Self-checking bench for score_accum: directed scenarios plus randomized notes
// scored by a rule-level model (lateness, timeouts, penalties, saturation).
module tb_score_accum;
    import piano_score_pkg::*;

    localparam int unsigned MW  = 64;
    localparam int unsigned PEN = 5;
    localparam longint unsigned SMAX = (64'd1 << 41) - 64'd1;

`ifdef SCORE_WRONG_KEY_PENALTY_EN
    localparam bit PEN_ON = 1'b1;
`else
    localparam bit PEN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        song_start;
    logic        song_end;
    logic        note_valid;
    logic [6:0]  expected_note;
    logic [6:0]  key_in;
    logic [40:0] score;
    logic        score_valid;
    logic        note_hit;
    logic        note_miss;
    logic        busy;
    state_t      dbg_state;

    int tests = 0;
    int fails = 0;
    longint unsigned model_score = 0;
    logic [40:0] exp_q[$];

    score_accum #(.MAX_WAIT(MW), .WRONG_PENALTY(PEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .song_start    (song_start),
        .song_end      (song_end),
        .note_valid    (note_valid),
        .expected_note (expected_note),
        .key_in        (key_in),
        .score         (score),
        .score_valid   (score_valid),
        .note_hit      (note_hit),
        .note_miss     (note_miss),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned sat(input longint unsigned x);
        return (x > SMAX) ? SMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end right after a falling edge.
    task automatic start_song();
        song_start = 1'b1;
        @(negedge clk);
        song_start = 1'b0;
        model_score = 0;
        chk("start_score", score, 0);
        chk("start_busy", busy, 0);
        chk("start_valid", score_valid, 0);
    endtask

    // One note: correct key rise lands at wait count w, optional wrong key at ww.
    task automatic do_note(input int w, input int ww, input int ek, input int wk,
                           input bit pre_en, input longint unsigned pre_val);
        bit hit;
        int k_ev;
        int k_last;
        longint unsigned add;
        logic [40:0] exp_s;
        hit   = (w <= int'(MW) - 1);
        k_ev  = hit ? w + 2 : int'(MW) + 1;
        add   = hit ? longint'(w) : longint'(MW);
        if (PEN_ON && ww != 0 && ww < w && ww <= int'(MW) - 2)
            add += PEN;
        if (pre_en)
            model_score = pre_val;
        model_score = sat(model_score + add);
        exp_q.push_back(model_score[40:0]);
        k_last = ((k_ev > w) ? k_ev : w);
        k_last = ((k_last > ww) ? k_last : ww) + 2;

        expected_note = 7'(1 << ek);
        note_valid = 1'b1;
        for (int k = 1; k <= k_last; k++) begin
            @(negedge clk);
            note_valid = 1'b0;
            chk("note_hit", note_hit, hit && k == k_ev);
            chk("note_miss", note_miss, !hit && k == k_ev);
            chk("busy", busy, k < k_ev);
            if (k == k_ev) begin
                exp_s = exp_q.pop_front();
                chk("note_score", score, exp_s);
            end
            if (k == 1 && pre_en) begin
                force dut.score_q = pre_val[40:0];
                #1;
                release dut.score_q;
            end
            key_in = '0;
            if (k >= w - 2)
                key_in = key_in | 7'(1 << ek);
            if (ww != 0 && k >= ww - 2)
                key_in = key_in | 7'(1 << wk);
        end
        key_in = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int ek;
        int wk;
        int w;
        int ww;
        int mode;
        rst_n = 1'b0;
        song_start = 1'b0;
        song_end = 1'b0;
        note_valid = 1'b0;
        expected_note = '0;
        key_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_score", score, 0);
        chk("rst_valid", score_valid, 0);
        chk("rst_hit", note_hit, 0);
        chk("rst_miss", note_miss, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // note_valid before song_start is ignored
        note_valid = 1'b1;
        expected_note = 7'b0000001;
        @(negedge clk);
        note_valid = 1'b0;
        @(negedge clk);
        chk("idle_ignore_busy", busy, 0);

        // hit 40 cycles after WAIT entry
        start_song();
        do_note(40, 0, 0, 1, 1'b0, 0);
        chk("hit40_score", score, 40);

        // timeout
        start_song();
        do_note(MW + 4, 0, 2, 3, 1'b0, 0);
        chk("timeout_score", score, MW);

        // wrong key at 4 then correct at 10
        start_song();
        do_note(10, 4, 0, 1, 1'b0, 0);
        chk("wrong_then_right", score, PEN_ON ? 15 : 10);

        // correct and wrong in the same cycle
        start_song();
        do_note(7, 7, 3, 5, 1'b0, 0);
        chk("same_cycle", score, 7);

        // correct key exactly in the timeout cycle counts as a hit
        start_song();
        do_note(MW - 1, 0, 6, 0, 1'b0, 0);
        chk("hit_at_timeout", score, MW - 1);

        // randomized song
        start_song();
        for (int n = 0; n < 10; n++) begin
            ek = $urandom_range(0, 6);
            wk = (ek + $urandom_range(1, 6)) % 7;
            w = $urandom_range(3, MW + 6);
            mode = $urandom_range(0, 3);
            if (mode == 0) ww = 0;
            else if (mode == 1) ww = w;
            else ww = $urandom_range(3, MW - 2);
            do_note(w, ww, ek, wk, 1'b0, 0);
        end

        // song_end in ARMED: DONE, frozen, note_valid ignored
        song_end = 1'b1;
        @(negedge clk);
        song_end = 1'b0;
        chk("done_valid", score_valid, 1);
        chk("done_score", score, model_score);
        note_valid = 1'b1;
        key_in = 7'h7f;
        @(negedge clk);
        note_valid = 1'b0;
        repeat (4) @(negedge clk);
        key_in = '0;
        chk("done_busy", busy, 0);
        chk("done_hold", score, model_score);
        chk("done_valid_hold", score_valid, 1);
        repeat (4) @(negedge clk);

        // song_end while a note is pending
        start_song();
        note_valid = 1'b1;
        expected_note = 7'b0000100;
        @(negedge clk);
        note_valid = 1'b0;
        repeat (4) @(negedge clk);
        song_end = 1'b1;
        @(negedge clk);
        song_end = 1'b0;
        chk("end_wait_score", score, MW);
        chk("end_wait_miss", note_miss, 0);
        chk("end_wait_valid", score_valid, 1);
        chk("end_wait_busy", busy, 0);

        // song_start mid-WAIT wins
        start_song();
        do_note(5, 0, 1, 2, 1'b0, 0);
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
        repeat (3) @(negedge clk);
        start_song();

        // saturation near 2^41-1
        do_note(MW + 3, 0, 4, 5, 1'b1, SMAX - 10);
        chk("sat_score", score, SMAX);
        song_end = 1'b1;
        @(negedge clk);
        song_end = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_valid", score_valid, 1);
        chk("sat_hold", score, SMAX);
        start_song();

        // reset mid-WAIT
        note_valid = 1'b1;
        expected_note = 7'b0000001;
        @(negedge clk);
        note_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_state", dbg_state, IDLE);
        chk("mid_rst_hit", note_hit, 0);
        chk("mid_rst_miss", note_miss, 0);
        chk("mid_rst_valid", score_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
        for (int k = 0; k < MW + 4; k++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_miss", note_miss, 0);
        end
        chk("post_rst_score", score, 0);
        start_song();
        do_note(12, 0, 2, 0, 1'b0, 0);
        chk("post_rst_note", score, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
